// File: rtl/imem_loader_pkg.sv
// Shared types and default sizing for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int N_WORDS_DEF = 64;
  localparam int ADDR_W_DEF  = 6;

  typedef logic [1:0] byte_idx_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready link from the host/debug side into the loader.
interface imem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word packer: byte k lands in bits [8k+7:8k].
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        clr_idx,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        full
);

  byte_idx_t   idx_q, idx_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clr) begin
      idx_d  = '0;
      word_d = '0;
    end else if (clr_idx) begin
      idx_d = '0;
    end else if (load) begin
      idx_d = idx_q + 2'd1;
      case (idx_q)
        2'd0:    word_d[7:0]   = byte_in;
        2'd1:    word_d[15:8]  = byte_in;
        2'd2:    word_d[23:16] = byte_in;
        default: word_d[31:24] = byte_in;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  // A load while full completes the word.
  assign full = (idx_q == 2'd3);
  assign word = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: byte stream in, one write strobe per assembled word out.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int N_WORDS = N_WORDS_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      in_if,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              last_q, last_d;
  logic              asm_clr, asm_clr_idx, asm_load, asm_full;
  logic              accept;

  assign accept = (state_q == COLLECT) && in_if.in_valid;

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    count_d     = count_q;
    last_d      = last_q;
    asm_clr     = 1'b0;
    asm_clr_idx = 1'b0;
    asm_load    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = COLLECT;
          waddr_d = '0;
          count_d = '0;
          last_d  = 1'b0;
          asm_clr = 1'b1;
        end
      end
      COLLECT: begin
        if (accept) begin
          asm_load = 1'b1;
          if (asm_full || in_if.in_last) begin
            state_d = WRITE;
            last_d  = in_if.in_last;
          end
        end
      end
      WRITE: begin
        count_d     = count_q + CNT_ONE;
        asm_clr_idx = 1'b1;
        // The assembly register is kept on the way to DONE so wdata stays put.
        if (last_q || (waddr_q == LAST_ADDR)) begin
          state_d = DONE;
        end else begin
          state_d = COLLECT;
          waddr_d = waddr_q + ADDR_ONE;
          asm_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      waddr_q <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  word_assembler u_asm (
    .clk     (clk),
    .reset   (reset),
    .clr     (asm_clr),
    .clr_idx (asm_clr_idx),
    .load    (asm_load),
    .byte_in (in_if.in_data),
    .word    (wdata),
    .full    (asm_full)
  );

  // All strobes decode straight from the state flop, so reset drops them without a clock.
  assign in_if.in_ready = (state_q == COLLECT);
  assign we             = (state_q == WRITE);
  assign busy           = (state_q == COLLECT) || (state_q == WRITE);
  assign done           = (state_q == DONE);
  assign waddr          = waddr_q;
  assign count          = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader driving a 64-word writable instruction memory model.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        we;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [6:0]  count;

  imem_loader_if bus ();

  imem_loader #(.N_WORDS(64), .ADDR_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in_if (bus),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .count (count)
  );

  // Instruction memory: write port fed by the loader, read port addr/q for readback.
  logic [31:0] mem [64];
  logic [31:0] exp_mem [64];
  logic [5:0]  addr;
  logic [31:0] q;
  assign q = mem[addr];

  always @(posedge clk) if (we) mem[waddr] <= wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard entries are {waddr, wdata}.
  logic [37:0] sb_q[$];
  logic [31:0] m_word;
  int          m_idx;
  int          m_addr;
  logic        gap_en;

  always @(negedge clk) begin
    if (reset && we) begin
      if (sb_q.size() == 0) begin
        check("we_unexpected", 1, 0);
      end else begin
        logic [37:0] e;
        e = sb_q.pop_front();
        check("waddr", waddr, e[37:32]);
        check("wdata", wdata, e[31:0]);
      end
    end
  end

  task automatic model_start();
    m_word = '0;
    m_idx  = 0;
    m_addr = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_start();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    if (gap_en) begin
      repeat ($urandom_range(0, 3)) begin
        if ($urandom_range(0, 1) == 1) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_last  = last;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      check("accept_timeout", 0, 1);
    end else begin
      @(posedge clk); #1;
      case (m_idx)
        0: m_word[7:0]   = b;
        1: m_word[15:8]  = b;
        2: m_word[23:16] = b;
        default: m_word[31:24] = b;
      endcase
      m_idx++;
      if (m_idx == 4 || last) begin
        sb_q.push_back({6'(m_addr), m_word});
        exp_mem[m_addr] = m_word;
        m_addr++;
        m_idx  = 0;
        m_word = '0;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    send_byte(w[7:0], 1'b0);
    send_byte(w[15:8], 1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[31:24], last);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", done, 1);
    check("busy_after_done", busy, 0);
    check("rdy_after_done", bus.in_ready, 0);
    check("sb_drained", sb_q.size(), 0);
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i < 64; i++) begin
      addr = 6'(i);
      #1;
      check(tag, q, exp_mem[i]);
    end
  endtask

  function automatic logic [31:0] img(input int i);
    return 32'h8B00_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  task automatic send_image(input int n_words);
    for (int i = 0; i < n_words; i++) send_word(img(i), (i == n_words - 1));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h5A5A_0000 | 32'(i);
      exp_mem[i] = 32'h5A5A_0000 | 32'(i);
    end
    addr         = '0;
    reset        = 1'b0;
    start        = 1'b0;
    gap_en       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    model_start();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Two hand-written words, second one terminated by in_last.
    do_start();
    check("start_busy", busy, 1);
    check("start_ready", bus.in_ready, 1);
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'hf8, 1'b0);
    send_byte(8'h02, 1'b0); send_byte(8'h80, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'hf8, 1'b1);
    wait_done();
    check("count_two", count, 2);
    addr = 6'd0; #1; check("word0_const", q, 32'hf800_0001);
    addr = 6'd1; #1; check("word1_const", q, 32'hf800_8002);

    // 47-word program image.
    do_start();
    check("restart_done_clr", done, 0);
    send_image(47);
    wait_done();
    check("count_47", count, 47);
    readback("rd_prog");

    // Partial word: two bytes with in_last.
    do_start();
    send_byte(8'haa, 1'b0);
    send_byte(8'hbb, 1'b1);
    wait_done();
    check("count_partial", count, 1);
    addr = 6'd0; #1; check("partial_const", q, 32'h0000_bbaa);

    // Overlong image: 64 words then 4 bytes that must stall.
    do_start();
    for (int i = 0; i < 64; i++) send_word(32'hC0DE_0000 ^ 32'(i * 7), 1'b0);
    wait_done();
    check("count_full", count, 64);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h11;
    repeat (4) begin
      check("excess_ready", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("count_full_hold", count, 64);
    readback("rd_full");

    // Program image again with random valid gaps and stray start pulses.
    do_start();
    gap_en = 1'b1;
    send_image(47);
    gap_en = 1'b0;
    wait_done();
    check("count_gaps", count, 47);
    readback("rd_gaps");

    // Asynchronous reset after two bytes of word 5.
    do_start();
    for (int i = 0; i < 5; i++) send_word(32'h1234_5600 | 32'(i), 1'b0);
    send_byte(8'h99, 1'b0);
    send_byte(8'h88, 1'b0);
    check("pre_rst_count", count, 5);
    check("pre_rst_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_we", we, 0);
    check("arst_busy", busy, 0);
    check("arst_count", count, 0);
    check("arst_ready", bus.in_ready, 0);
    check("arst_wdata", wdata, 0);
    check("arst_sb", sb_q.size(), 0);
    model_start();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", busy, 0);
    do_start();
    send_image(47);
    wait_done();
    check("count_reload", count, 47);
    readback("rd_reload");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
